// File: rtl/comp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_t : sequencer states (2-bit encoding)
//   RES_*   : result encoding on {l,e,g}
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b001;

endpackage

// File: rtl/comp_bit_slice.sv
// Purely combinational 1-bit magnitude compare built from 2:1 muxes.
//   ai, bi : operand bits
//   li     : ai < bi
//   ei     : ai == bi
//   gi     : ai > bi
module comp_bit_slice (
  input  logic ai,
  input  logic bi,
  output logic li,
  output logic ei,
  output logic gi
);

  // ai selects between the two possible answers for each flag
  always_comb begin
    li = ai ? 1'b0 : bi;
    ei = ai ? bi   : ~bi;
    gi = ai ? ~bi  : 1'b0;
  end

endmodule

// File: rtl/comp_serial_seq.sv
// Serial MSB-first magnitude comparator of two W-bit unsigned operands using
// a single 1-bit compare slice; stops at the first differing bit.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   start  : compare request, accepted whenever not busy
//   a, b   : operands, captured on the accepting edge
//   busy   : compare in progress
//   done   : one-cycle result-valid pulse
//   l/e/g  : registered A<B / A==B / A>B, held until the next accepted start
module comp_serial_seq #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         l,
  output logic         e,
  output logic         g
);
  import comp_pkg::*;

  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [IW-1:0]  idx;
  logic [2:0]     res_r;
  logic           ai, bi;
  logic           li, ei, gi;
  logic           accept;
  logic           last_bit;

  // A 1-bit operand has nothing to index; select the only bit directly
  if (W == 1) begin : g_one_bit
    assign ai = a_r[0];
    assign bi = b_r[0];
  end else begin : g_multi_bit
    assign ai = a_r[idx];
    assign bi = b_r[idx];
  end

  comp_bit_slice u_slice (
    .ai (ai),
    .bi (bi),
    .li (li),
    .ei (ei),
    .gi (gi)
  );

  always_comb begin
    accept   = start && (state != RUN);
    last_bit = (idx == '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; DONE accepts start directly so compares run back-to-back
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (!ei || last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, index and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      res_r <= '0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      idx   <= IW'(W - 1);
      res_r <= '0;
    end else if (state == RUN) begin
      if (gi)            res_r <= RES_GT;
      else if (li)       res_r <= RES_LT;
      else if (last_bit) res_r <= RES_EQ;
      else               idx   <= idx - 1'b1;
    end
  end

  // Output logic
  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    {l, e, g} = res_r;
  end

endmodule

// File: tb/tb_comp_serial_seq.sv
module tb_comp_serial_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start1;
  logic [7:0] a, b;
  logic [0:0] a1, b1;
  logic       busy, done, l, e, g;
  logic       busy1, done1, l1, e1, g1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  comp_serial_seq #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .l(l), .e(e), .g(g)
  );

  comp_serial_seq #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .l(l1), .e(e1), .g(g1)
  );

  // Drives one start pulse and observes the W=8 instance until done
  // (bounded at 20 cycles; lat stays 0 on timeout). Reports done cycle,
  // flags at done, number of busy cycles and flags seen in cycle 1.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      output int lat, output logic [2:0] res,
                      output int busy_cnt, output logic [2:0] run_flags);
    lat = 0; busy_cnt = 0; res = 3'b000; run_flags = 3'b111;
    @(posedge clk); #1;
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) run_flags = {l, e, g};
      if (busy) busy_cnt++;
      if (done) begin
        lat = c; res = {l, e, g};
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    a = '0; b = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, done, l, e, g} !== 5'b00000) begin
      fails++; $display("FAIL reset_w8: got %b want 00000", {busy, done, l, e, g});
    end
    tests++;
    if ({busy1, done1, l1, e1, g1} !== 5'b00000) begin
      fails++; $display("FAIL reset_w1: got %b want 00000", {busy1, done1, l1, e1, g1});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_msb_exit;
    int lat, bc; logic [2:0] res, rf;
    run8(8'h80, 8'h7F, lat, res, bc, rf);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL msb_latency: got %0d want 2", lat); end
    tests++;
    if (res !== 3'b001) begin fails++; $display("FAIL msb_flags: got %b want 001", res); end
    tests++;
    if (bc !== 1) begin fails++; $display("FAIL msb_busy_cycles: got %0d want 1", bc); end
    tests++;
    if (rf !== 3'b000) begin fails++; $display("FAIL msb_run_flags: got %b want 000", rf); end
  endtask

  task automatic test_mid_word;
    int lat, bc; logic [2:0] res, rf;
    run8(8'h10, 8'h30, lat, res, bc, rf);
    tests++;
    if (lat !== 4 || res !== 3'b100) begin
      fails++; $display("FAIL mid_10_30: got lat=%0d flags=%b want lat=4 flags=100", lat, res);
    end
    tests++;
    if (bc !== 3) begin fails++; $display("FAIL mid_busy_cycles: got %0d want 3", bc); end
    run8(8'h03, 8'h02, lat, res, bc, rf);
    tests++;
    if (lat !== 9 || res !== 3'b001) begin
      fails++; $display("FAIL mid_03_02: got lat=%0d flags=%b want lat=9 flags=001", lat, res);
    end
  endtask

  task automatic test_equal_hold;
    int lat, bc; logic [2:0] res, rf;
    run8(8'h5A, 8'h5A, lat, res, bc, rf);
    tests++;
    if (lat !== 9 || res !== 3'b010) begin
      fails++; $display("FAIL equal_5a: got lat=%0d flags=%b want lat=9 flags=010", lat, res);
    end
    tests++;
    if (bc !== 8) begin fails++; $display("FAIL equal_busy_cycles: got %0d want 8", bc); end
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, l, e, g} !== 5'b00010) begin
      fails++; $display("FAIL equal_hold: got %b want 00010", {busy, done, l, e, g});
    end
  endtask

  task automatic test_busy_ignore;
    int lat; logic [2:0] res;
    lat = 0; res = 3'b000;
    @(posedge clk); #1;
    start = 1'b1; a = 8'h5A; b = 8'h5A;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin start = 1'b1; a = 8'h00; b = 8'hFF; end
      else if (c == 4) begin start = 1'b0; end
      @(negedge clk);
      if (done) begin lat = c; res = {l, e, g}; break; end
      @(posedge clk); #1;
    end
    tests++;
    if (lat !== 9 || res !== 3'b010) begin
      fails++; $display("FAIL busy_ignore: got lat=%0d flags=%b want lat=9 flags=010", lat, res);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [2:0] res; logic b1st;
    int lat1;
    lat = 0; lat1 = 0; res = 3'b000; b1st = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 8'h80; b = 8'h7F;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin lat1 = c; break; end
    end
    // still inside the DONE cycle: request the next compare
    start = 1'b1; a = 8'h03; b = 8'h05;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) b1st = busy;
      if (done) begin lat = c; res = {l, e, g}; break; end
    end
    tests++;
    if (lat1 !== 2) begin fails++; $display("FAIL b2b_first_latency: got %0d want 2", lat1); end
    tests++;
    if (b1st !== 1'b1) begin fails++; $display("FAIL b2b_busy_next: got %b want 1", b1st); end
    tests++;
    if (lat !== 7 || res !== 3'b100) begin
      fails++; $display("FAIL b2b_second: got lat=%0d flags=%b want lat=7 flags=100", lat, res);
    end
  endtask

  task automatic test_reset_mid_run;
    int done_seen;
    done_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; a = 8'h5A; b = 8'h5A;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, done, l, e, g} !== 5'b00000) begin
      fails++; $display("FAIL reset_mid_run: got %b want 00000", {busy, done, l, e, g});
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    tests++;
    if (done_seen !== 0) begin
      fails++; $display("FAIL reset_no_done: got %0d pulses want 0", done_seen);
    end
  endtask

  task automatic test_w1;
    logic [2:0] exp_res [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
    for (int k = 0; k < 4; k++) begin
      int lat; logic [2:0] res; logic [1:0] ab;
      lat = 0; res = 3'b000; ab = 2'(k);
      @(posedge clk); #1;
      start1 = 1'b1; a1 = ab[1]; b1 = ab[0];
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (done1) begin lat = c; res = {l1, e1, g1}; break; end
      end
      tests++;
      if (lat !== 2 || res !== exp_res[k]) begin
        fails++;
        $display("FAIL w1_ab%b: got lat=%0d flags=%b want lat=2 flags=%b", ab, lat, res, exp_res[k]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_msb_exit;
    test_mid_word;
    test_equal_hold;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid_run;
    test_w1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
